// File: rtl/srio_tx_arb.sv
// Packet-granular two-source arbiter onto one SRIO transmit AXI-Stream.
// Whole packets are granted (round-robin or fixed priority); runaway packets are cut at MAX_BEATS.
`timescale 1ns/1ps
module srio_tx_arb #(
  parameter int MAX_BEATS = 33,
  parameter int CNT_W     = 16
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic             S0_AXIS_TVALID,
  output logic             S0_AXIS_TREADY,
  input  logic [63:0]      S0_AXIS_TDATA,
  input  logic             S0_AXIS_TLAST,
  input  logic [31:0]      S0_AXIS_TUSER,
  input  logic             S1_AXIS_TVALID,
  output logic             S1_AXIS_TREADY,
  input  logic [63:0]      S1_AXIS_TDATA,
  input  logic             S1_AXIS_TLAST,
  input  logic [31:0]      S1_AXIS_TUSER,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [63:0]      M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  output logic [31:0]      M_AXIS_TUSER,
  output logic [7:0]       M_AXIS_TKEEP,
  input  logic [1:0]       src_enable,
  input  logic             prio_mode,
  input  logic [1:0]       overrun_clr,
  output logic [1:0]       grant,
  output logic [1:0]       overrun,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);
  localparam int BC_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state, state_nx;
  logic            sel;
  logic            rr_ptr;
  logic [BC_W-1:0] beat_cnt;
  logic            req0, req1, pick;
  logic            g_valid, g_last, g_ready;
  logic [63:0]     g_data;
  logic [31:0]     g_user;
  logic            at_max, m_hs, pkt_end, trunc;

  assign M_AXIS_TKEEP = 8'hff;

  assign req0 = S0_AXIS_TVALID & src_enable[0];
  assign req1 = S1_AXIS_TVALID & src_enable[1];
  // rr_ptr=0 favours S0; with a single requester, that one wins.
  assign pick = (req0 & req1) ? (prio_mode ? 1'b0 : rr_ptr) : ~req0;

  assign g_valid = sel ? S1_AXIS_TVALID : S0_AXIS_TVALID;
  assign g_last  = sel ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
  assign g_data  = sel ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
  assign g_user  = sel ? S1_AXIS_TUSER  : S0_AXIS_TUSER;

  assign at_max  = (beat_cnt == BC_W'(MAX_BEATS - 1));
  assign m_hs    = (state == STREAM) & g_valid & M_AXIS_TREADY;
  assign pkt_end = m_hs & (g_last | at_max);
  assign trunc   = m_hs & at_max & ~g_last;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) state <= IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    g_ready       = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TUSER  = '0;
    M_AXIS_TLAST  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) state_nx = STREAM;
      end
      STREAM: begin
        M_AXIS_TVALID = g_valid;
        M_AXIS_TDATA  = g_data;
        M_AXIS_TUSER  = g_user;
        M_AXIS_TLAST  = g_last | at_max;
        g_ready       = M_AXIS_TREADY;
        if (m_hs) begin
          if (g_last)      state_nx = IDLE;
          else if (at_max) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // Swallow the rest of a truncated packet without touching the link.
        g_ready = 1'b1;
        if (g_valid & g_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    S0_AXIS_TREADY = g_ready & ~sel;
    S1_AXIS_TREADY = g_ready &  sel;
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      grant    <= 2'b00;
      sel      <= 1'b0;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
      overrun  <= 2'b00;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            sel      <= pick;
            grant    <= pick ? 2'b10 : 2'b01;
            beat_cnt <= '0;
          end
        end
        STREAM: begin
          if (m_hs) beat_cnt <= beat_cnt + 1'b1;
          if (pkt_end) begin
            rr_ptr <= ~sel;
            if (g_last) grant <= 2'b00;
          end
        end
        DRAIN: begin
          if (g_valid & g_last) grant <= 2'b00;
        end
        default: grant <= 2'b00;
      endcase
      if (pkt_end & ~sel) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (pkt_end &  sel) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      // A new truncation beats a simultaneous clear.
      overrun <= (overrun & ~overrun_clr) | {trunc & sel, trunc & ~sel};
    end
  end
endmodule
